// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } pipe_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int DEF_MULT_CYCLES = 4;
    localparam int DEF_DIV_CYCLES  = 32;
    localparam int DEF_CNT_W       = 6;

endpackage

// File: rtl/hazard_lu_detect.sv
// rtl/hazard_lu_detect.sv - combinational load-use hazard comparator
module hazard_lu_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    output logic       lu
);

    logic rs_hit;
    logic rt_hit;

    // $0 is hardwired, so a load targeting it never creates a dependency
    assign rs_hit = id_use_rs && (ex_rd == id_rs);
    assign rt_hit = id_use_rt && (ex_rd == id_rt);
    assign lu     = ex_mem_read && (ex_rd != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the 5-stage MIPS pipeline
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        id_branch_taken,
    input  logic        id_mdu_start,
    input  logic        id_mdu_is_div,
    input  logic        ext_flush,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_count
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

    pipe_state_e      state;
    pipe_state_e      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             lu;

    hazard_lu_detect u_lu (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .lu          (lu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= '0;
            stall_count <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (!pc_en && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        mdu_busy    = 1'b0;
        mdu_done    = 1'b0;
        state_next  = state;
        cnt_next    = cnt;

        if (rst) begin
            state_next = RUN;
            cnt_next   = '0;
        end else if (ext_flush) begin
            // exception wins over everything, including an in-flight MDU op
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_next  = RUN;
            cnt_next    = '0;
        end else if (state == RUN && lu) begin
            id_ex_flush = 1'b1;
        end else if (state == MDU_WAIT) begin
            mdu_busy = 1'b1;
            if (cnt != '0) begin
                id_ex_flush = 1'b1;
                cnt_next    = cnt - 1'b1;
            end else begin
                // final cycle: release ID without re-launching the same MDU op
                pc_en      = 1'b1;
                if_id_en   = 1'b1;
                mdu_done   = 1'b1;
                state_next = RUN;
            end
        end else if (id_mdu_start) begin
            id_ex_flush = 1'b1;
            mdu_busy    = 1'b1;
            state_next  = MDU_WAIT;
            cnt_next    = id_mdu_is_div ? DIV_LOAD : MULT_LOAD;
        end else if (id_branch_taken) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
        end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    typedef struct packed {
        logic        pc_en;
        logic        if_id_en;
        logic        if_id_flush;
        logic        id_ex_flush;
        logic        mdu_busy;
        logic        mdu_done;
        logic [31:0] stall_count;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_use_rs, id_use_rt, ex_mem_read;
    logic        id_branch_taken, id_mdu_start, id_mdu_is_div, ext_flush;
    logic        pc_en, if_id_en, if_id_flush, id_ex_flush, mdu_busy, mdu_done;
    logic [31:0] stall_count;

    pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .id_branch_taken (id_branch_taken),
        .id_mdu_start    (id_mdu_start),
        .id_mdu_is_div   (id_mdu_is_div),
        .ext_flush       (ext_flush),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mdu_busy        (mdu_busy),
        .mdu_done        (mdu_done),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // reference model: cycles still owed to an MDU op after the current one
    int          m_left = 0;
    logic [31:0] m_stalls = 0;

    function automatic logic ref_lu();
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));
    endfunction

    task automatic apply();
        exp_t e;
        e = '0;
        e.stall_count = m_stalls;
        if (rst) begin
            m_left = 0;
        end else if (ext_flush) begin
            {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_flush} = 4'b1111;
            m_left = 0;
        end else if (m_left == 0 && ref_lu()) begin
            e.id_ex_flush = 1'b1;
        end else if (m_left > 1) begin
            e.id_ex_flush = 1'b1;
            e.mdu_busy    = 1'b1;
            m_left--;
        end else if (m_left == 1) begin
            {e.pc_en, e.if_id_en, e.mdu_busy, e.mdu_done} = 4'b1111;
            m_left = 0;
        end else if (id_mdu_start) begin
            e.id_ex_flush = 1'b1;
            e.mdu_busy    = 1'b1;
            m_left = (id_mdu_is_div ? DIV_N : MULT_N) - 1;
        end else if (id_branch_taken) begin
            {e.pc_en, e.if_id_en, e.if_id_flush} = 3'b111;
        end else begin
            {e.pc_en, e.if_id_en} = 2'b11;
        end
        q.push_back(e);
        if (rst) m_stalls = 0;
        else if (!e.pc_en && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; id_rs = 0; id_rt = 0; ex_rd = 0;
        id_use_rs = 0; id_use_rt = 0; ex_mem_read = 0;
        id_branch_taken = 0; id_mdu_start = 0; id_mdu_is_div = 0; ext_flush = 0;
    endtask

    exp_t m_exp;
    exp_t m_act;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_exp = q.pop_front();
            m_act = {pc_en, if_id_en, if_id_flush, id_ex_flush, mdu_busy, mdu_done, stall_count};
            vectors++;
            if (m_act !== m_exp) begin
                miscompares++;
                $display("FAIL outputs t=%0t got pc_en/if_id_en/ifl/idl/busy/done=%b%b%b%b%b%b cnt=%0d, want %b%b%b%b%b%b cnt=%0d",
                         $time, m_act.pc_en, m_act.if_id_en, m_act.if_id_flush, m_act.id_ex_flush,
                         m_act.mdu_busy, m_act.mdu_done, m_act.stall_count,
                         m_exp.pc_en, m_exp.if_id_en, m_exp.if_id_flush, m_exp.id_ex_flush,
                         m_exp.mdu_busy, m_exp.mdu_done, m_exp.stall_count);
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        apply();
        apply();
        rst = 0;
        apply();

        // load-use on rs, then resume
        ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
        apply();
        idle_inputs();
        apply();
        // load-use on rt
        ex_mem_read = 1; ex_rd = 9; id_rt = 9; id_use_rt = 1; id_rs = 9;
        apply();
        idle_inputs();
        // $0 never stalls
        ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
        apply();
        idle_inputs();
        // branch alone, then branch with load-use
        id_branch_taken = 1;
        apply();
        ex_mem_read = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
        apply();
        idle_inputs();

        // full DIV with the MDU instruction parked in ID
        id_mdu_start = 1; id_mdu_is_div = 1;
        for (int i = 0; i < DIV_N; i++) apply();
        idle_inputs();
        apply();
        // full MULT with a load-use present during the wait
        id_mdu_start = 1;
        for (int i = 0; i < MULT_N; i++) begin
            ex_mem_read = (i == 1); ex_rd = 4; id_rs = 4; id_use_rs = 1;
            apply();
        end
        idle_inputs();
        apply();

        // exception at cycle 10 of a DIV
        id_mdu_start = 1; id_mdu_is_div = 1;
        for (int i = 0; i < 9; i++) apply();
        ext_flush = 1;
        apply();
        idle_inputs();
        for (int i = 0; i < 4; i++) apply();

        // reset at cycle 2 of a MULT
        id_mdu_start = 1;
        apply();
        rst = 1;
        apply();
        idle_inputs();
        for (int i = 0; i < 6; i++) apply();

        for (int i = 0; i < 2500; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            ext_flush       = ($urandom_range(0, 59) == 0);
            id_mdu_start    = ($urandom_range(0, 24) == 0);
            id_mdu_is_div   = $urandom_range(0, 1) == 1;
            id_branch_taken = ($urandom_range(0, 4) == 0);
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            ex_rd           = 5'($urandom_range(0, 3));
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            id_use_rs       = $urandom_range(0, 1) == 1;
            id_use_rt       = $urandom_range(0, 1) == 1;
            apply();
        end
        idle_inputs();
        apply();

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
